// File: rtl/d_cache_dm.sv
// Direct-mapped, write-back, write-allocate data cache with a miss FSM
// (compare / write-back / fill) and a whole-cache flush walker.
module d_cache_dm #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int LINE_WORDS = 4,
    parameter int NUM_SETS   = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int OW    = $clog2(LINE_WORDS);
    localparam int IW    = $clog2(NUM_SETS);
    localparam int TW    = ADDR_W - IW - OW;
    localparam int OWC   = (OW > 0) ? OW : 1;
    localparam int IWC   = (IW > 0) ? IW : 1;
    localparam int DEPTH = NUM_SETS * LINE_WORDS;
    localparam int DWC   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, FILL, FLUSH} state_t;

    // Absent fields (OW or IW of 0) collapse to a 1-bit counter masked to 0.
    function automatic logic [OWC-1:0] f_off(input logic [ADDR_W-1:0] a);
        return OWC'(a) & OWC'(LINE_WORDS - 1);
    endfunction

    function automatic logic [IWC-1:0] f_idx(input logic [ADDR_W-1:0] a);
        return IWC'(a >> OW) & IWC'(NUM_SETS - 1);
    endfunction

    function automatic logic [TW-1:0] f_tag(input logic [ADDR_W-1:0] a);
        return TW'(a >> (OW + IW));
    endfunction

    function automatic logic [ADDR_W-1:0] f_maddr(input logic [TW-1:0] tag,
                                                 input logic [IWC-1:0] idx,
                                                 input logic [OWC-1:0] off);
        return (ADDR_W'(tag) << (IW + OW)) | (ADDR_W'(idx) << OW) | ADDR_W'(off);
    endfunction

    function automatic logic [DWC-1:0] f_didx(input logic [IWC-1:0] idx,
                                             input logic [OWC-1:0] off);
        return DWC'(int'(idx) * LINE_WORDS + int'(off));
    endfunction

    state_t              r_state;
    logic [DATA_W-1:0]   r_data [0:DEPTH-1];
    logic [TW-1:0]       r_tag  [0:NUM_SETS-1];
    logic [NUM_SETS-1:0] r_valid;
    logic [NUM_SETS-1:0] r_dirty;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [OWC-1:0]      r_word;
    logic [IWC-1:0]      r_set;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_flush_done;

    logic [IWC-1:0]    w_idx;
    logic [OWC-1:0]    w_off;
    logic [TW-1:0]     w_tag;
    logic [TW-1:0]     w_vtag;
    logic              w_hit;
    logic              w_vdirty;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_ack;
    logic [OWC-1:0]    w_word_nx;
    logic              w_word_last;
    logic [IWC-1:0]    w_set_nx;
    logic              w_set_last;
    logic              w_set_dirty;
    logic              w_set_done;

    assign w_idx       = f_idx(r_addr);
    assign w_off       = f_off(r_addr);
    assign w_tag       = f_tag(r_addr);
    assign w_vtag      = r_tag[w_idx];
    assign w_hit       = r_valid[w_idx] && (w_vtag == w_tag);
    assign w_vdirty    = r_valid[w_idx] && r_dirty[w_idx];
    assign w_rd_word   = r_data[f_didx(w_idx, w_off)];
    assign w_ack       = r_mem_req && mem_ack;
    assign w_word_nx   = (r_word + OWC'(1)) & OWC'(LINE_WORDS - 1);
    assign w_word_last = (r_word == OWC'(LINE_WORDS - 1));
    assign w_set_nx    = (r_set + IWC'(1)) & IWC'(NUM_SETS - 1);
    assign w_set_last  = (r_set == IWC'(NUM_SETS - 1));
    assign w_set_dirty = r_valid[r_set] && r_dirty[r_set];
    assign w_set_done  = r_mem_req ? (w_ack && w_word_last) : !w_set_dirty;

    // The response is decoded from the COMPARE-cycle lookup so a hit answers one cycle after acceptance.
    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == COMPARE) && w_hit;
    assign resp_rdata = resp_valid ? (r_we ? r_wdata : w_rd_word) : '0;
    assign flush_done = r_flush_done;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_word       <= '0;
            r_set        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (flush_req) begin
                        r_set   <= '0;
                        r_state <= FLUSH;
                    end else if (req_valid) begin
                        r_addr  <= req_addr;
                        r_we    <= req_we;
                        r_wdata <= req_wdata;
                        r_state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (w_hit) begin
                        if (r_we) begin
                            r_data[f_didx(w_idx, w_off)] <= r_wdata;
                            r_dirty[w_idx]               <= 1'b1;
                        end
                        r_state <= IDLE;
                    end else begin
                        r_word    <= '0;
                        r_mem_req <= 1'b1;
                        if (w_vdirty) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= f_maddr(w_vtag, w_idx, '0);
                            r_mem_wdata <= r_data[f_didx(w_idx, '0)];
                            r_state     <= WRITEBACK;
                        end else begin
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= f_maddr(w_tag, w_idx, '0);
                            r_state     <= FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (w_ack) begin
                        if (w_word_last) begin
                            r_dirty[w_idx] <= 1'b0;
                            r_word         <= '0;
                            r_mem_we       <= 1'b0;
                            r_mem_addr     <= f_maddr(w_tag, w_idx, '0);
                            r_state        <= FILL;
                        end else begin
                            r_word      <= w_word_nx;
                            r_mem_addr  <= f_maddr(w_vtag, w_idx, w_word_nx);
                            r_mem_wdata <= r_data[f_didx(w_idx, w_word_nx)];
                        end
                    end
                end
                FILL: begin
                    if (w_ack) begin
                        r_data[f_didx(w_idx, r_word)] <= mem_rdata;
                        if (w_word_last) begin
                            r_tag[w_idx]   <= w_tag;
                            r_valid[w_idx] <= 1'b1;
                            r_dirty[w_idx] <= 1'b0;
                            r_mem_req      <= 1'b0;
                            r_state        <= COMPARE;
                        end else begin
                            r_word     <= w_word_nx;
                            r_mem_addr <= f_maddr(w_tag, w_idx, w_word_nx);
                        end
                    end
                end
                FLUSH: begin
                    if (r_mem_req) begin
                        if (w_ack && w_word_last) begin
                            r_mem_req      <= 1'b0;
                            r_mem_we       <= 1'b0;
                            r_dirty[r_set] <= 1'b0;
                        end else if (w_ack) begin
                            r_word      <= w_word_nx;
                            r_mem_addr  <= f_maddr(r_tag[r_set], r_set, w_word_nx);
                            r_mem_wdata <= r_data[f_didx(r_set, w_word_nx)];
                        end
                    end else if (w_set_dirty) begin
                        r_word      <= '0;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= f_maddr(r_tag[r_set], r_set, '0);
                        r_mem_wdata <= r_data[f_didx(r_set, '0)];
                    end
                    if (w_set_done) begin
                        if (w_set_last) begin
                            r_set        <= '0;
                            r_flush_done <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_set <= w_set_nx;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_d_cache_dm.sv
// Directed bench for d_cache_dm: default geometry plus a 1-set/1-word instance,
// with a backing-memory model returning 0xA000|addr[11:0] and logging every word.
module tb_d_cache_dm;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } mlog_t;

    typedef struct {
        bit          sel;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
    } vec_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        req_valid, req_ready, req_we, resp_valid, flush_req, flush_done;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        req_valid_s, req_ready_s, req_we_s, resp_valid_s, flush_req_s, flush_done_s;
    logic        mem_req_s, mem_we_s, mem_ack_s;
    logic [15:0] req_addr_s, req_wdata_s, resp_rdata_s, mem_addr_s, mem_wdata_s, mem_rdata_s;

    int    n_checks = 0;
    int    n_errors = 0;
    int    ack_delay = 0;
    int    wait_cnt = 0;
    bit    held = 1'b0;
    logic [32:0] prev_word;
    mlog_t log1[$];
    mlog_t log2[$];

    always #5 clk = ~clk;

    d_cache_dm #(.ADDR_W(16), .DATA_W(16), .LINE_WORDS(4), .NUM_SETS(16)) u_dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .flush_req(flush_req), .flush_done(flush_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    d_cache_dm #(.ADDR_W(16), .DATA_W(16), .LINE_WORDS(1), .NUM_SETS(1)) u_small (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid_s), .req_ready(req_ready_s), .req_we(req_we_s),
        .req_addr(req_addr_s), .req_wdata(req_wdata_s),
        .resp_valid(resp_valid_s), .resp_rdata(resp_rdata_s),
        .flush_req(flush_req_s), .flush_done(flush_done_s),
        .mem_req(mem_req_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
        .mem_ack(mem_ack_s), .mem_rdata(mem_rdata_s)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Main memory: ack after ack_delay waiting cycles; held words must not change.
    always @(negedge clk) begin
        if (mem_req) begin
            if (held) check("mem_stable", {mem_we, mem_addr, mem_wdata}, prev_word);
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'hA000 | {4'h0, mem_addr[11:0]};
                log1.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
                wait_cnt  = 0;
                held      = 1'b0;
            end else begin
                mem_ack   = 1'b0;
                wait_cnt++;
                held      = 1'b1;
                prev_word = {mem_we, mem_addr, mem_wdata};
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
            held     = 1'b0;
        end
    end

    always @(negedge clk) begin
        mem_ack_s   = mem_req_s;
        mem_rdata_s = 16'hA000 | {4'h0, mem_addr_s[11:0]};
        if (mem_req_s) log2.push_back('{mem_we_s, mem_addr_s, mem_we_s ? mem_wdata_s : mem_rdata_s});
    end

    task automatic do_req(input bit sel, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, output logic [15:0] rdata, output int lat);
        int n = 0;
        @(negedge clk);
        if (sel) begin
            req_valid_s = 1'b1; req_we_s = we; req_addr_s = addr; req_wdata_s = wdata;
        end else begin
            req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        end
        while (!(sel ? req_ready_s : req_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("accept_timeout", sel ? req_ready_s : req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        req_valid_s = 1'b0;
        lat = 1;
        while (!(sel ? resp_valid_s : resp_valid) && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 500) check("resp_timeout", sel ? resp_valid_s : resp_valid, 1);
        rdata = sel ? resp_rdata_s : resp_rdata;
    endtask

    task automatic do_flush(input bit with_req, output int cycles, output bit early);
        @(negedge clk);
        flush_req = 1'b1;
        if (with_req) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0921; req_wdata = '0;
        end
        @(negedge clk);
        flush_req = 1'b0;
        cycles = 0;
        early = 1'b0;
        while (!flush_done && cycles < 2000) begin
            if (req_ready) early = 1'b1;
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 2000) check("flush_timeout", flush_done, 1);
    endtask

    task automatic chk_log(input bit sel, input int i, input bit we,
                           input logic [15:0] addr, input logic [15:0] data);
        mlog_t e;
        int    sz = sel ? log2.size() : log1.size();
        if (i >= sz) begin
            check($sformatf("log%0d_len", sel), sz, i + 1);
        end else begin
            e = sel ? log2[i] : log1[i];
            check($sformatf("log%0d[%0d]_we", sel, i), e.we, we);
            check($sformatf("log%0d[%0d]_addr", sel, i), e.addr, addr);
            if (we) check($sformatf("log%0d[%0d]_wdata", sel, i), e.data, data);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[10];
        logic [15:0] wb_exp[4];
        logic [15:0] fl_exp[4];
        logic [15:0] rd;
        int          lat, base, nr, nw, cyc, sz;
        bit          early;
        mlog_t       e;

        n_rst = 1'b0;
        {req_valid, req_we, flush_req} = '0;
        {req_valid_s, req_we_s, flush_req_s} = '0;
        req_addr = '0; req_wdata = '0; req_addr_s = '0; req_wdata_s = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_small_ready", req_ready_s, 1);
        check("rst_small_mem_req", mem_req_s, 0);
        n_rst = 1'b1;

        tbl[0] = '{0, 0, 16'h0120, 16'h0000, 16'hA120,  6, 4, 0};
        tbl[1] = '{0, 0, 16'h0122, 16'h0000, 16'hA122,  1, 0, 0};
        tbl[2] = '{0, 1, 16'h0121, 16'hBEEF, 16'hBEEF,  1, 0, 0};
        tbl[3] = '{0, 0, 16'h0121, 16'h0000, 16'hBEEF,  1, 0, 0};
        tbl[4] = '{0, 0, 16'h0920, 16'h0000, 16'hA920, 10, 4, 4};
        tbl[5] = '{0, 1, 16'h0920, 16'h1234, 16'h1234,  1, 0, 0};
        tbl[6] = '{0, 0, 16'h0FFF, 16'h0000, 16'hAFFF,  6, 4, 0};
        tbl[7] = '{1, 0, 16'h0005, 16'h0000, 16'hA005,  3, 1, 0};
        tbl[8] = '{1, 1, 16'h0006, 16'h5A5A, 16'h5A5A,  3, 1, 0};
        tbl[9] = '{1, 0, 16'h0005, 16'h0000, 16'hA005,  4, 1, 1};

        for (int i = 0; i < 10; i++) begin
            base = tbl[i].sel ? log2.size() : log1.size();
            do_req(tbl[i].sel, tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, lat);
            sz = tbl[i].sel ? log2.size() : log1.size();
            nr = 0;
            nw = 0;
            for (int k = base; k < sz; k++) begin
                e = tbl[i].sel ? log2[k] : log1[k];
                if (e.we) nw++;
                else nr++;
            end
            check($sformatf("v%0d_rdata", i), rd, tbl[i].rdata);
            check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("v%0d_reads", i), nr, tbl[i].nrd);
            check($sformatf("v%0d_writes", i), nw, tbl[i].nwr);
        end

        wb_exp = '{16'hA120, 16'hBEEF, 16'hA122, 16'hA123};
        for (int k = 0; k < 4; k++) begin
            chk_log(0, k,      0, 16'(16'h0120 + k), '0);
            chk_log(0, 4 + k,  1, 16'(16'h0120 + k), wb_exp[k]);
            chk_log(0, 8 + k,  0, 16'(16'h0920 + k), '0);
            chk_log(0, 12 + k, 0, 16'(16'h0FFC + k), '0);
        end
        chk_log(1, 0, 0, 16'h0005, '0);
        chk_log(1, 1, 0, 16'h0006, '0);
        chk_log(1, 2, 1, 16'h0006, 16'h5A5A);
        chk_log(1, 3, 0, 16'h0005, '0);

        // Flush with only set 8 dirty: four write-backs, then the clean walk.
        base = log1.size();
        do_flush(0, cyc, early);
        check("flush1_cycles", cyc, 20);
        check("flush1_ready_early", early, 0);
        check("flush1_writes", log1.size() - base, 4);
        fl_exp = '{16'h1234, 16'hA921, 16'hA922, 16'hA923};
        for (int k = 0; k < 4; k++) chk_log(0, base + k, 1, 16'(16'h0920 + k), fl_exp[k]);
        @(negedge clk);
        check("flush1_done_pulse", flush_done, 0);

        base = log1.size();
        do_flush(0, cyc, early);
        check("flush2_cycles", cyc, 16);
        check("flush2_traffic", log1.size() - base, 0);
        @(negedge clk);
        check("flush2_done_pulse", flush_done, 0);

        do_flush(1, cyc, early);
        check("flush3_cycles", cyc, 16);
        check("flush3_ready_early", early, 0);
        @(negedge clk);
        req_valid = 1'b0;
        check("flush3_resp_valid", resp_valid, 1);
        check("flush3_resp_rdata", resp_rdata, 16'hA921);
        check("flush3_done_pulse", flush_done, 0);

        ack_delay = 5;
        base = log1.size();
        do_req(0, 0, 16'h0520, '0, rd, lat);
        check("slow_rdata", rd, 16'hA520);
        check("slow_latency", lat, 26);
        check("slow_reads", log1.size() - base, 4);

        // Reset while a fill is outstanding.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0120;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("midfill_mem_req", mem_req, 1);
        n_rst = 1'b0;
        @(negedge clk);
        check("midrst_mem_req", mem_req, 0);
        check("midrst_mem_we", mem_we, 0);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_resp_valid", resp_valid, 0);
        n_rst = 1'b1;
        ack_delay = 0;
        base = log1.size();
        do_req(0, 0, 16'h0120, '0, rd, lat);
        check("postrst_rdata", rd, 16'hA120);
        check("postrst_latency", lat, 6);
        check("postrst_reads", log1.size() - base, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/d_cache_dm.md
Name: d_cache_dm

Overview:
- Parametrised direct-mapped, write-back, write-allocate data cache for the pipelined core's memory stage.
- Sits between the memory-stage load/store request port and a word-wide backing-memory port.
- Replaces the flat byte array with tag/valid/dirty arrays, a miss state machine and a whole-cache flush.

Parameters:
- ADDR_W, 16: word-address width.
- DATA_W, 16: word width.
- LINE_WORDS, 4: words per line; power of 2, >=1.
- NUM_SETS, 16: number of lines; power of 2, >=1.

Ports:
- clk  in  1  clock
- n_rst  in  1  synchronous active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  cache can accept request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  DATA_W  load data, or stored data for stores
- flush_req  in  1  write back all dirty lines
- flush_done  out  1  one-cycle pulse when flush completes
- mem_req  out  1  backing-memory word request
- mem_we  out  1  1 = write-back word, 0 = fill read
- mem_addr  out  ADDR_W  backing word address
- mem_wdata  out  DATA_W  write-back data
- mem_ack  in  1  current word accepted; for reads, mem_rdata valid
- mem_rdata  in  DATA_W  fill data

Behaviour:
- Reset and clocking: reset n_rst, synchronous, active-low; clock clk.
- Reset values:
  - all valid and dirty bits cleared
  - req_ready=1, resp_valid=0, flush_done=0, mem_req=0, mem_we=0
  - mem_addr, mem_wdata and resp_rdata are 0
  - data and tag arrays are not reset
- Reset mid-operation: any in-progress fill, write-back or flush is abandoned. mem_req is 0 in the first cycle n_rst is sampled low.
- Address split:
  - offset = addr[OW-1:0], OW=log2(LINE_WORDS)
  - index = next IW bits, IW=log2(NUM_SETS)
  - tag = remaining ADDR_W-IW-OW bits
  - OW=0 or IW=0 is legal; the field is absent.
- Handshake:
  - A request is accepted when req_valid && req_ready. req_ready=1 only in IDLE.
  - The requester holds inputs stable until accepted.
  - resp_valid has no backpressure.
- Flush arbitration: flush_req is sampled only in IDLE and wins over a simultaneous req_valid. The request waits; req_ready=0 during the flush.
- States: IDLE, COMPARE, WRITEBACK, FILL, FLUSH.
- IDLE -> COMPARE: on acceptance; the request is registered.
- IDLE -> FLUSH: on flush_req; set counter reset to 0.
- COMPARE, hit (valid && tag match):
  - resp_valid=1 this cycle, so latency is 1 cycle after acceptance.
  - Load: resp_rdata = word.
  - Store: word written, dirty=1, resp_rdata = req_wdata.
  - Next state IDLE.
- COMPARE, miss: go to WRITEBACK if the victim is valid and dirty, else FILL.
- WRITEBACK:
  - Words 0..LINE_WORDS-1 written in order to {victim_tag, index, i}.
  - mem_we=1; a word counter advances on mem_ack.
  - After the last ack: dirty=0, go to FILL.
- FILL:
  - Words 0..LINE_WORDS-1 read in order from {req_tag, index, i}; mem_we=0.
  - mem_rdata is written into the line on each ack.
  - After the last ack: tag updated, valid=1, dirty=0, go to COMPARE. COMPARE then hits, so the store-allocate is finished there.
- Memory protocol:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable while mem_req=1 and mem_ack=0.
  - The next word may be presented in the cycle after an ack; mem_req may stay high back-to-back.
  - mem_ack while mem_req=0 is ignored.
- FLUSH:
  - Each set in turn, 0..NUM_SETS-1.
  - Valid && dirty set: write back all LINE_WORDS words, then dirty=0. Valid bits are kept.
  - Clean or invalid set: skipped in 1 cycle with no memory traffic.
  - After the last set: flush_done=1 for one cycle, go to IDLE.
- Counter wrap: word and set counters wrap to 0 after their last value. A single-entry counter is a constant 0.

Test Plan:
- Defaults; memory model returns 0xA000|addr[11:0].
- Cold load 0x0120 -> FILL reads 0x0120..0x0123; resp_rdata=0xA120. Then load 0x0122 -> resp_valid 1 cycle after accept, 0xA122, no mem_req.
- Store 0x0121 data 0xBEEF (hit) -> no mem_req, resp_rdata=0xBEEF. Load 0x0121 -> 0xBEEF.
- Load 0x0920 (same index 8, tag 0x24, victim dirty):
  - writes 0x0120..0x0123 with data A120, BEEF, A122, A123
  - then reads 0x0920..0x0923
  - resp_rdata=0x A920 → value 0xA920
- flush_req with set 8 dirty (store 0x0920 data 0x1234 first):
  - exactly 4 writes, to 0x0920..0x0923, then one flush_done pulse
  - a second flush produces no mem_req and flush_done after NUM_SETS cycles
  - flush_req and req_valid together -> flush completes before req_ready rises
- mem_ack delayed 5 cycles per word -> mem_addr and mem_wdata stable throughout. Reset asserted mid-FILL -> mem_req=0 next cycle; after reset, load 0x0120 misses again.
- NUM_SETS=1, LINE_WORDS=1:
  - load 0x0005 miss, 1 read
  - store 0x0006 -> 1 read fill, dirty
  - load 0x0005 -> 1 write to 0x0006, then 1 read
